// File: rtl/rob_unit.sv
// Eight-entry reorder buffer: in-order allocation at the expected tail, result
// capture from the CDB, and in-order retirement of ready entries from the head.
module rob_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              alloc_valid,
  input  logic [2:0]        alloc_idx,
  input  logic [2:0]        alloc_op,
  input  logic [REG_AW-1:0] alloc_dest,
  input  logic              cdb_valid,
  input  logic [2:0]        cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              commit_stall,
  input  logic [2:0]        rd_idx0,
  input  logic [2:0]        rd_idx1,
  output logic              rd_ready0,
  output logic              rd_ready1,
  output logic [DATA_W-1:0] rd_value0,
  output logic [DATA_W-1:0] rd_value1,
  output logic [7:0]        busy_rb,
  output logic              commit_valid,
  output logic [2:0]        commit_op,
  output logic [REG_AW-1:0] commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output logic [2:0]        rob_head,
  output logic [3:0]        rob_count,
  output logic              alloc_err
);

  logic [7:0]        busy_q;
  logic [7:0]        ready_q;
  logic [2:0]        op_q    [8];
  logic [REG_AW-1:0] dest_q  [8];
  logic [DATA_W-1:0] value_q [8];
  logic [2:0]        head_q;
  logic [2:0]        tail_q;
  logic [3:0]        count_q;

  logic alloc_ok;
  logic alloc_bad;
  logic cdb_ok;
  logic commit_ok;

  // alloc_valid and cdb_valid are single-cycle requests with no back-pressure,
  // sampled on every rising edge; commit_stall is the downstream not-ready, and
  // a retire transfers only on an edge where commit_stall is low.
  always_comb begin
    alloc_ok  = alloc_valid && !busy_q[alloc_idx] && (alloc_idx == tail_q);
    alloc_bad = alloc_valid && !alloc_ok;
    cdb_ok    = cdb_valid && busy_q[cdb_tag] && !ready_q[cdb_tag];
    commit_ok = busy_q[head_q] && ready_q[head_q] && !commit_stall;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !start) begin
      busy_q       <= 8'h00;
      ready_q      <= 8'h00;
      head_q       <= 3'd0;
      tail_q       <= 3'd0;
      count_q      <= 4'd0;
      commit_valid <= 1'b0;
      commit_op    <= 3'd0;
      commit_dest  <= '0;
      commit_value <= '0;
      alloc_err    <= 1'b0;
    end else begin
      if (alloc_ok) begin
        busy_q[alloc_idx]  <= 1'b1;
        ready_q[alloc_idx] <= 1'b0;
        op_q[alloc_idx]    <= alloc_op;
        dest_q[alloc_idx]  <= alloc_dest;
        tail_q             <= tail_q + 3'd1;
      end
      if (alloc_bad) begin
        alloc_err <= 1'b1;
      end
      // The CDB checks pre-edge busy, so a same-cycle alloc to its tag drops it.
      if (cdb_ok) begin
        ready_q[cdb_tag] <= 1'b1;
        value_q[cdb_tag] <= cdb_value;
      end
      commit_valid <= commit_ok;
      if (commit_ok) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_q + 3'd1;
        commit_op       <= op_q[head_q];
        commit_dest     <= dest_q[head_q];
        commit_value    <= value_q[head_q];
      end
      count_q <= count_q + {3'd0, alloc_ok} - {3'd0, commit_ok};
    end
  end

  assign rd_ready0 = busy_q[rd_idx0] & ready_q[rd_idx0];
  assign rd_ready1 = busy_q[rd_idx1] & ready_q[rd_idx1];
  assign rd_value0 = value_q[rd_idx0];
  assign rd_value1 = value_q[rd_idx1];
  assign busy_rb   = busy_q;
  assign rob_head  = head_q;
  assign rob_count = count_q;

endmodule

// File: tb/tb_rob_unit.sv
// Testbench for rob_unit: directed scenarios plus randomized traffic against an
// in-order queue model of the reorder buffer.
module tb_rob_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        alloc_valid;
  logic [2:0]  alloc_idx;
  logic [2:0]  alloc_op;
  logic [4:0]  alloc_dest;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        commit_stall;
  logic [2:0]  rd_idx0;
  logic [2:0]  rd_idx1;
  logic        rd_ready0;
  logic        rd_ready1;
  logic [31:0] rd_value0;
  logic [31:0] rd_value1;
  logic [7:0]  busy_rb;
  logic        commit_valid;
  logic [2:0]  commit_op;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  logic [2:0]  rob_head;
  logic [3:0]  rob_count;
  logic        alloc_err;

  int n_checks = 0;
  int n_fail   = 0;

  rob_unit #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_op(alloc_op),
    .alloc_dest(alloc_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .commit_stall(commit_stall),
    .rd_idx0(rd_idx0), .rd_idx1(rd_idx1), .rd_ready0(rd_ready0),
    .rd_ready1(rd_ready1), .rd_value0(rd_value0), .rd_value1(rd_value1),
    .busy_rb(busy_rb), .commit_valid(commit_valid), .commit_op(commit_op),
    .commit_dest(commit_dest), .commit_value(commit_value),
    .rob_head(rob_head), .rob_count(rob_count), .alloc_err(alloc_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // In-flight instructions in program order; the front is the oldest.
  typedef struct {
    logic [2:0]  idx;
    logic [2:0]  op;
    logic [4:0]  dest;
    bit          rdy;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  int          m_head = 0;
  int          m_tail = 0;
  bit          m_err  = 0;
  bit          m_cv   = 0;
  logic [2:0]  m_cop  = 0;
  logic [4:0]  m_cdest = 0;
  logic [31:0] m_cval = 0;

  function automatic logic [7:0] exp_busy();
    logic [7:0] b = 8'h00;
    foreach (q[i]) b[q[i].idx] = 1'b1;
    return b;
  endfunction

  function automatic void exp_rd(input logic [2:0] idx, output bit r, output logic [31:0] v);
    r = 0;
    v = 0;
    foreach (q[i]) if (q[i].idx == idx && q[i].rdy) begin r = 1; v = q[i].val; end
  endfunction

  // Applies the inputs present at this edge to the model.
  task automatic model_edge();
    bit   do_commit;
    bit   idx_busy;
    ent_t e;
    if (!rst_n || !start) begin
      q.delete();
      m_head = 0; m_tail = 0; m_err = 0;
      m_cv = 0; m_cop = 0; m_cdest = 0; m_cval = 0;
      return;
    end
    do_commit = (q.size() > 0) && q[0].rdy && !commit_stall;
    idx_busy = 0;
    foreach (q[i]) if (q[i].idx == alloc_idx) idx_busy = 1;
    if (cdb_valid)
      foreach (q[i]) if (q[i].idx == cdb_tag && !q[i].rdy) begin
        q[i].rdy = 1;
        q[i].val = cdb_value;
      end
    m_cv = do_commit;
    if (do_commit) begin
      e = q.pop_front();
      m_cop = e.op; m_cdest = e.dest; m_cval = e.val;
      m_head = (m_head + 1) % 8;
    end
    if (alloc_valid) begin
      if (!idx_busy && alloc_idx == 3'(m_tail)) begin
        e.idx = alloc_idx; e.op = alloc_op; e.dest = alloc_dest; e.rdy = 0; e.val = 0;
        q.push_back(e);
        m_tail = (m_tail + 1) % 8;
      end else begin
        m_err = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit av, input logic [2:0] ai, input logic [2:0] ao,
                     input logic [4:0] ad, input bit cv, input logic [2:0] ct,
                     input logic [31:0] cval, input bit st);
    alloc_valid = av; alloc_idx = ai; alloc_op = ao; alloc_dest = ad;
    cdb_valid = cv; cdb_tag = ct; cdb_value = cval; commit_stall = st;
    @(posedge clk);
    model_edge();
    #1;
    alloc_valid = 0; cdb_valid = 0; commit_stall = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; start = 1;
    idle();
    idle();
    rst_n = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cyc(1, 0, 1, 1, 0, 0, 0, 0);
    do_reset();
    n_checks++; if (busy_rb !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got %h want 00", busy_rb); end
    n_checks++; if (rob_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rob_count); end
    n_checks++; if (rob_head !== 3'd0) begin n_fail++; $display("FAIL reset_head: got %0d want 0", rob_head); end
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cv: got %b want 0", commit_valid); end
    n_checks++; if (alloc_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", alloc_err); end
    n_checks++; if (commit_value !== 32'd0) begin n_fail++; $display("FAIL reset_cval: got %h want 0", commit_value); end
  endtask

  task automatic test_single();
    do_reset();
    cyc(1, 0, 3'd0, 5'd3, 0, 0, 0, 0);
    n_checks++; if (busy_rb !== 8'h01) begin n_fail++; $display("FAIL single_busy: got %h want 01", busy_rb); end
    rd_idx0 = 0;
    cyc(0, 0, 0, 0, 1, 0, 32'h1234, 0);
    n_checks++; if (rd_ready0 !== 1'b1) begin n_fail++; $display("FAIL single_rdready: got %b want 1", rd_ready0); end
    n_checks++; if (rd_value0 !== 32'h1234) begin n_fail++; $display("FAIL single_rdvalue: got %h want 1234", rd_value0); end
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_cv: got %b want 0", commit_valid); end
    idle();
    n_checks++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL single_cv: got %b want 1", commit_valid); end
    n_checks++; if (commit_dest !== 5'd3) begin n_fail++; $display("FAIL single_dest: got %0d want 3", commit_dest); end
    n_checks++; if (commit_value !== 32'h1234) begin n_fail++; $display("FAIL single_value: got %h want 1234", commit_value); end
    n_checks++; if (commit_op !== 3'd0) begin n_fail++; $display("FAIL single_op: got %0d want 0", commit_op); end
    n_checks++; if (busy_rb !== 8'h00) begin n_fail++; $display("FAIL single_busy_after: got %h want 00", busy_rb); end
    n_checks++; if (rob_head !== 3'd1) begin n_fail++; $display("FAIL single_head: got %0d want 1", rob_head); end
    idle();
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", commit_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 3'(i), 3'(i + 1), 5'(10 + i), 0, 0, 0, 0);
    n_checks++; if (rob_count !== 4'd3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", rob_count); end
    for (int i = 2; i >= 0; i--) begin
      cyc(0, 0, 0, 0, 1, 3'(i), 32'h200 + 32'(i), 0);
      n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_nocommit: tag %0d got %b want 0", i, commit_valid); end
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_cv: slot %0d got %b want 1", i, commit_valid); end
      n_checks++; if (commit_dest !== 5'(10 + i)) begin n_fail++; $display("FAIL b2b_dest: got %0d want %0d", commit_dest, 10 + i); end
      n_checks++; if (commit_value !== 32'h200 + 32'(i)) begin n_fail++; $display("FAIL b2b_value: got %h want %h", commit_value, 32'h200 + 32'(i)); end
      n_checks++; if (rob_count !== 4'(2 - i)) begin n_fail++; $display("FAIL b2b_count_dec: got %0d want %0d", rob_count, 2 - i); end
    end
    idle();
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", commit_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 3'(i), 3'(i % 6), 5'(i), 0, 0, 0, 0);
    n_checks++; if (busy_rb !== 8'hFF) begin n_fail++; $display("FAIL full_busy: got %h want ff", busy_rb); end
    n_checks++; if (rob_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", rob_count); end
    n_checks++; if (alloc_err !== 1'b0) begin n_fail++; $display("FAIL full_noerr: got %b want 0", alloc_err); end
    cyc(1, 0, 3'd1, 5'd9, 0, 0, 0, 0);
    n_checks++; if (alloc_err !== 1'b1) begin n_fail++; $display("FAIL full_err: got %b want 1", alloc_err); end
    n_checks++; if (rob_count !== 4'd8) begin n_fail++; $display("FAIL full_rejected: got %0d want 8", rob_count); end
    cyc(0, 0, 0, 0, 1, 0, 32'hCAFE, 0);
    idle();
    n_checks++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_cv: got %b want 1", commit_valid); end
    n_checks++; if (busy_rb !== 8'hFE) begin n_fail++; $display("FAIL wrap_busy: got %h want fe", busy_rb); end
    cyc(1, 0, 3'd5, 5'd20, 0, 0, 0, 0);
    n_checks++; if (busy_rb !== 8'hFF) begin n_fail++; $display("FAIL wrap_alloc: got %h want ff", busy_rb); end
    n_checks++; if (rob_head !== 3'd1) begin n_fail++; $display("FAIL wrap_head: got %0d want 1", rob_head); end
    n_checks++; if (rob_count !== 4'd8) begin n_fail++; $display("FAIL wrap_count: got %0d want 8", rob_count); end
  endtask

  task automatic test_stall();
    do_reset();
    cyc(1, 0, 3'd2, 5'd7, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'hBEEF, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(i == 0, 3'd1, 3'd4, 5'd8, 0, 0, 0, 1);
      n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL stall_cv: cycle %0d got %b want 0", i, commit_valid); end
      n_checks++; if (rob_head !== 3'd0) begin n_fail++; $display("FAIL stall_head: cycle %0d got %0d want 0", i, rob_head); end
    end
    n_checks++; if (busy_rb !== 8'h03) begin n_fail++; $display("FAIL stall_alloc: got %h want 03", busy_rb); end
    idle();
    n_checks++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", commit_valid); end
    n_checks++; if (commit_value !== 32'hBEEF) begin n_fail++; $display("FAIL stall_value: got %h want beef", commit_value); end
    n_checks++; if (commit_op !== 3'd2) begin n_fail++; $display("FAIL stall_op: got %0d want 2", commit_op); end
  endtask

  task automatic test_start_drop();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 3'(i), 3'd0, 5'(i), 0, 0, 0, 0);
    cyc(1, 3'd1, 3'd0, 5'd0, 0, 0, 0, 0);
    n_checks++; if (rob_count !== 4'd4) begin n_fail++; $display("FAIL drop_pre_count: got %0d want 4", rob_count); end
    n_checks++; if (alloc_err !== 1'b1) begin n_fail++; $display("FAIL drop_pre_err: got %b want 1", alloc_err); end
    start = 0;
    cyc(0, 0, 0, 0, 1, 0, 32'h55, 0);
    start = 1;
    n_checks++; if (busy_rb !== 8'h00) begin n_fail++; $display("FAIL drop_busy: got %h want 00", busy_rb); end
    n_checks++; if (rob_count !== 4'd0) begin n_fail++; $display("FAIL drop_count: got %0d want 0", rob_count); end
    n_checks++; if (alloc_err !== 1'b0) begin n_fail++; $display("FAIL drop_err: got %b want 0", alloc_err); end
    idle();
    n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL drop_cv: got %b want 0", commit_valid); end
    cyc(1, 0, 3'd3, 5'd4, 0, 0, 0, 0);
    n_checks++; if (busy_rb !== 8'h01) begin n_fail++; $display("FAIL drop_realloc: got %h want 01", busy_rb); end
    n_checks++; if (alloc_err !== 1'b0) begin n_fail++; $display("FAIL drop_realloc_err: got %b want 0", alloc_err); end
  endtask

  task automatic test_random();
    bit          av, cv, st, r0, r1;
    logic [2:0]  ai, ct;
    logic [31:0] v0, v1;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rd_idx0 = 3'($urandom_range(0, 7));
      rd_idx1 = 3'($urandom_range(0, 7));
      #1;
      exp_rd(rd_idx0, r0, v0);
      exp_rd(rd_idx1, r1, v1);
      n_checks++; if (rd_ready0 !== r0 || (r0 && rd_value0 !== v0)) begin n_fail++; $display("FAIL rand_rd0: cyc %0d got %b/%h want %b/%h", n, rd_ready0, rd_value0, r0, v0); end
      n_checks++; if (rd_ready1 !== r1 || (r1 && rd_value1 !== v1)) begin n_fail++; $display("FAIL rand_rd1: cyc %0d got %b/%h want %b/%h", n, rd_ready1, rd_value1, r1, v1); end
      av = $urandom_range(0, 99) < 55;
      ai = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'(m_tail);
      cv = $urandom_range(0, 99) < 50;
      ct = (q.size() > 0 && $urandom_range(0, 4) != 0) ? q[$urandom_range(0, q.size() - 1)].idx
                                                       : 3'($urandom_range(0, 7));
      st = $urandom_range(0, 99) < 25;
      start = ($urandom_range(0, 149) != 0);
      cyc(av, ai, 3'($urandom_range(0, 5)), 5'($urandom), cv, ct, $urandom, st);
      start = 1;
      n_checks++; if (busy_rb !== exp_busy()) begin n_fail++; $display("FAIL rand_busy: cyc %0d got %h want %h", n, busy_rb, exp_busy()); end
      n_checks++; if (rob_count !== 4'(q.size())) begin n_fail++; $display("FAIL rand_count: cyc %0d got %0d want %0d", n, rob_count, q.size()); end
      n_checks++; if (rob_head !== 3'(m_head)) begin n_fail++; $display("FAIL rand_head: cyc %0d got %0d want %0d", n, rob_head, m_head); end
      n_checks++; if (commit_valid !== m_cv) begin n_fail++; $display("FAIL rand_cv: cyc %0d got %b want %b", n, commit_valid, m_cv); end
      n_checks++; if (alloc_err !== m_err) begin n_fail++; $display("FAIL rand_err: cyc %0d got %b want %b", n, alloc_err, m_err); end
      n_checks++; if ({commit_op, commit_dest, commit_value} !== {m_cop, m_cdest, m_cval}) begin
        n_fail++;
        $display("FAIL rand_commit: cyc %0d got %0d/%0d/%h want %0d/%0d/%h", n, commit_op, commit_dest, commit_value, m_cop, m_cdest, m_cval);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 0; start = 1;
    alloc_valid = 0; alloc_idx = 0; alloc_op = 0; alloc_dest = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; commit_stall = 0;
    rd_idx0 = 0; rd_idx1 = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_wrap();
    test_stall();
    test_start_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
